// File: rtl/led_share_sched.sv
// Shares the four user LEDs between up to four status requesters, round-robin,
// and shows a rotating heartbeat whenever nobody holds them.
module led_share_sched #(
    parameter int TICK_DIV   = 2500000,
    parameter int HOLD_TICKS = 2
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [3:0]  req,
    input  logic [15:0] pat,
    output logic [3:0]  grant,
    output logic [3:0]  done,
    output logic [3:0]  led,
    output logic        busy,
    output logic        tick
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT   = 2'd1;
    localparam logic [1:0] ST_HOLD    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int HW = (HOLD_TICKS > 2) ? $clog2(HOLD_TICKS) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRESC_PRE  = PW'(TICK_DIV - 2);
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
    localparam logic [PW-1:0] PRESC_ZERO = PW'(0);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_TICKS - 1);
    localparam logic [HW-1:0] HOLD_ONE   = HW'(1);
    localparam logic [HW-1:0] HOLD_ZERO  = HW'(0);

    logic [PW-1:0] presc_r;
    logic          tick_r;
    logic [1:0]    state_r,    state_s;
    logic [1:0]    winner_r,   winner_s;
    logic [1:0]    rr_ptr_r,   rr_ptr_s;
    logic [HW-1:0] hold_cnt_r, hold_cnt_s;
    logic [3:0]    hb_r,       hb_s;
    logic [3:0]    led_r,      led_s;
    logic [3:0]    grant_r,    grant_s;
    logic [3:0]    done_r,     done_s;
    logic          busy_r,     busy_s;

    // First set request bit strictly after ptr, wrapping; ptr itself is checked last.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] ptr);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        idx   = ptr;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = idx + 2'd1;
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [3:0] onehot4(input logic [1:0] i);
        return 4'b0001 << i;
    endfunction

    // Free-running prescaler; tick is registered one count early so it aligns with the last count.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            presc_r <= PRESC_ZERO;
            tick_r  <= 1'b0;
        end else begin
            presc_r <= (presc_r == PRESC_LAST) ? PRESC_ZERO : (presc_r + PRESC_ONE);
            tick_r  <= (presc_r == PRESC_PRE);
        end
    end

    // Arbitration, hold timing and output next-values.
    always_comb begin
        state_s    = state_r;
        winner_s   = winner_r;
        rr_ptr_s   = rr_ptr_r;
        hold_cnt_s = hold_cnt_r;
        hb_s       = hb_r;
        led_s      = led_r;
        grant_s    = grant_r;
        done_s     = 4'b0000;
        case (state_r)
            ST_IDLE: begin
                if (|req) begin
                    winner_s = rr_pick(req, rr_ptr_r);
                    state_s  = ST_GRANT;
                end else if (tick_r) begin
                    hb_s  = {hb_r[2:0], hb_r[3]};
                    led_s = {hb_r[2:0], hb_r[3]};
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                grant_s    = onehot4(winner_r);
                led_s      = pat[{winner_r, 2'b00} +: 4];
                hold_cnt_s = HOLD_ZERO;
                state_s    = ST_HOLD;
            end
            ST_HOLD: begin
                // A dropped request wins over a final tick in the same cycle.
                if (!req[winner_r]) begin
                    state_s  = ST_RELEASE;
                    grant_s  = 4'b0000;
                    led_s    = hb_r;
                    rr_ptr_s = winner_r;
                end else if (tick_r) begin
                    if (hold_cnt_r == HOLD_LAST) begin
                        state_s  = ST_RELEASE;
                        grant_s  = 4'b0000;
                        led_s    = hb_r;
                        rr_ptr_s = winner_r;
                        done_s   = onehot4(winner_r);
                    end else begin
                        hold_cnt_s = hold_cnt_r + HOLD_ONE;
                    end
                end else begin
                    state_s = ST_HOLD;
                end
            end
            ST_RELEASE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                grant_s = 4'b0000;
                led_s   = hb_r;
            end
        endcase
        busy_s = (state_s != ST_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r    <= ST_IDLE;
            winner_r   <= 2'd0;
            rr_ptr_r   <= 2'd3;
            hold_cnt_r <= HOLD_ZERO;
            hb_r       <= 4'b0001;
            led_r      <= 4'b0001;
            grant_r    <= 4'b0000;
            done_r     <= 4'b0000;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            winner_r   <= winner_s;
            rr_ptr_r   <= rr_ptr_s;
            hold_cnt_r <= hold_cnt_s;
            hb_r       <= hb_s;
            led_r      <= led_s;
            grant_r    <= grant_s;
            done_r     <= done_s;
            busy_r     <= busy_s;
        end
    end

    assign grant = grant_r;
    assign done  = done_r;
    assign led   = led_r;
    assign busy  = busy_r;
    assign tick  = tick_r;

endmodule

// File: tb/tb_led_share_sched.sv
// Self-checking bench for led_share_sched: directed scenarios plus random traffic,
// all compared cycle by cycle against an event-level reference model.
module tb_led_share_sched;

    localparam int TICK_DIV   = 4;
    localparam int HOLD_TICKS = 2;

    logic        clk;
    logic        nrst;
    logic [3:0]  req;
    logic [15:0] pat;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic [3:0]  led;
    logic        busy;
    logic        tick;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: who is being served, how many ticks it has been shown, heartbeat position.
    int       m_n;
    int       m_hb;
    int       m_owner;
    int       m_last;
    int       m_ticks;
    bit       m_tick;
    bit       m_shown;
    bit       m_cool;
    logic [3:0] m_pat;
    logic [3:0] m_done;

    led_share_sched #(.TICK_DIV(TICK_DIV), .HOLD_TICKS(HOLD_TICKS)) dut (
        .clk   (clk),
        .nrst  (nrst),
        .req   (req),
        .pat   (pat),
        .grant (grant),
        .done  (done),
        .led   (led),
        .busy  (busy),
        .tick  (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_n = 0; m_hb = 0; m_owner = -1; m_last = 3; m_ticks = 0;
        m_tick = 1'b0; m_shown = 1'b0; m_cool = 1'b0;
        m_pat = 4'b0000; m_done = 4'b0000;
    endtask

    function automatic int first_after(input logic [3:0] r, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    task automatic finish_service(input bit completed);
        m_last  = m_owner;
        m_done  = completed ? (4'b0001 << m_owner) : 4'b0000;
        m_owner = -1;
        m_shown = 1'b0;
        m_cool  = 1'b1;
    endtask

    task automatic model_edge(input logic [3:0] r, input logic [15:0] p);
        bit old_tick;
        old_tick = m_tick;
        m_n++;
        m_tick = ((m_n % TICK_DIV) == TICK_DIV - 1);
        m_done = 4'b0000;
        if (m_cool) begin
            m_cool = 1'b0;
        end else if (m_owner < 0) begin
            if (r != 4'b0000) m_owner = first_after(r, m_last);
            else if (old_tick) m_hb = (m_hb + 1) % 4;
        end else if (!m_shown) begin
            m_shown = 1'b1;
            m_pat   = p[4*m_owner +: 4];
            m_ticks = 0;
        end else if (!r[m_owner]) begin
            finish_service(1'b0);
        end else if (old_tick) begin
            m_ticks++;
            if (m_ticks == HOLD_TICKS) finish_service(1'b1);
        end
    endtask

    task automatic check_all();
        logic [3:0] eg;
        logic [3:0] el;
        eg = m_shown ? (4'b0001 << m_owner) : 4'b0000;
        el = m_shown ? m_pat : (4'b0001 << m_hb);
        chk("grant", grant, eg);
        chk("done",  done,  m_done);
        chk("led",   led,   el);
        chk("busy",  {3'b000, busy}, {3'b000, (m_owner >= 0) || m_cool});
        chk("tick",  {3'b000, tick}, {3'b000, m_tick});
    endtask

    task automatic step();
        logic [3:0]  r;
        logic [15:0] p;
        r = req;
        p = pat;
        @(posedge clk);
        model_edge(r, p);
        #1;
        check_all();
    endtask

    // Called just after a sampling point, so reset edges stay clear of clk edges.
    task automatic do_reset();
        nrst = 1'b0;
        #2;
        model_reset();
        check_all();
        chk("rst_grant", grant, 4'b0000);
        chk("rst_led",   led,   4'b0001);
        chk("rst_busy",  {3'b000, busy}, 4'b0000);
        #3;
        nrst = 1'b1;
    endtask

    task automatic wait_grant(input string tag, input int budget);
        for (int i = 0; i < budget && grant == 4'b0000; i++) step();
        chk(tag, {3'b000, |grant}, 4'b0001);
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget && done == 4'b0000; i++) step();
        chk(tag, {3'b000, |done}, 4'b0001);
    endtask

    initial begin
        logic [3:0] seq [5];
        logic [3:0] exp_seq [5];
        logic [3:0] prev;
        int ns;
        int tick_cnt;

        nrst = 1'b0;
        req  = 4'b0000;
        pat  = 16'h0000;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Idle heartbeat: five ticks in twenty cycles.
        tick_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (tick) tick_cnt++;
        end
        chk("t1_tick_count", 4'(tick_cnt), 4'd5);

        // Single requester 1 runs to completion.
        req = 4'b0010;
        pat = 16'h00A0;
        wait_grant("t2_grant_wait", 5);
        chk("t2_led", led, 4'b1010);
        wait_done("t2_done_wait", 20);
        chk("t2_done", done, 4'b0010);
        chk("t2_grant_off", grant, 4'b0000);
        req = 4'b0000;
        step();
        step();

        // All four requesting: strict rotation from requester 0.
        do_reset();
        req = 4'b1111;
        pat = 16'hC953;
        exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
        exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;
        ns = 0;
        prev = 4'b0000;
        for (int i = 0; i < 80 && ns < 5; i++) begin
            step();
            if (grant != 4'b0000 && prev == 4'b0000) begin
                seq[ns] = grant;
                ns++;
            end
            prev = grant;
        end
        chk("t3_grant_count", 4'(ns), 4'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < ns) chk("t3_order", seq[k], exp_seq[k]);
            else chk("t3_order_missing", 4'b0000, exp_seq[k]);
        end
        req = 4'b0000;
        for (int i = 0; i < 4; i++) step();

        // Requester 2 abandons after one tick; pending requester 3 goes next.
        req = 4'b0100;
        pat = 16'h3C00;
        wait_grant("t4_grant_wait", 6);
        chk("t4_grant2", grant, 4'b0100);
        req = 4'b1100;
        for (int i = 0; i < 10 && tick !== 1'b1; i++) step();
        chk("t4_tick_seen", {3'b000, tick}, 4'b0001);
        step();
        for (int i = 0; i < 10 && tick !== 1'b1; i++) step();
        req = 4'b1000;
        step();
        chk("t4_no_done", done, 4'b0000);
        chk("t4_released", grant, 4'b0000);
        wait_grant("t4_next_wait", 6);
        chk("t4_next_grant", grant, 4'b1000);
        wait_done("t4_done3_wait", 20);
        req = 4'b0000;
        step();
        step();

        // Abandon on the cycle of the final tick: no done.
        req = 4'b0010;
        wait_grant("t4b_grant_wait", 6);
        for (int i = 0; i < 10 && tick !== 1'b1; i++) step();
        step();
        for (int i = 0; i < 10 && tick !== 1'b1; i++) step();
        chk("t4b_final_tick", {3'b000, tick}, 4'b0001);
        req = 4'b0000;
        step();
        chk("t4b_no_done", done, 4'b0000);
        step();
        step();

        // Pattern latched at grant; later changes ignored.
        req = 4'b0001;
        pat = 16'h0006;
        wait_grant("t5_grant_wait", 6);
        step();
        pat = 16'h0009;
        for (int i = 0; i < 20 && done == 4'b0000; i++) begin
            if (grant != 4'b0000) chk("t5_led_latched", led, 4'b0110);
            step();
        end
        chk("t5_done", done, 4'b0001);
        req = 4'b0000;
        step();
        step();

        // Reset during hold aborts, then requester 0 is first again.
        req = 4'b0010;
        wait_grant("t6_grant_wait", 6);
        step();
        step();
        do_reset();
        chk("t6_done_rst", done, 4'b0000);
        req = 4'b0011;
        wait_grant("t6_after_rst_wait", 6);
        chk("t6_first_winner", grant, 4'b0001);
        req = 4'b0000;
        step();

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) req = 4'($urandom);
            if ($urandom_range(0, 3) == 0) pat = 16'($urandom);
            step();
            if (i == 200) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
